// File: rtl/uart_tx_piso.sv
// UART transmitter: latches a byte plus parity into an 11-bit frame
// and shifts it out LSB first, holding each bit TICKS_PER_BIT baud_clk edges.
module uart_tx_piso #(
    parameter int unsigned TICKS_PER_BIT = 16
) (
    input  logic       baud_clk,
    input  logic       reset_n,
    input  logic       send,
    input  logic [7:0] data_in,
    input  logic [1:0] parity_type,
    output logic       data_tx,
    output logic       active_flag,
    output logic       done_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } state_e;

    localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);
    localparam logic [3:0] BIT_LAST  = 4'd10;

    state_e      state_q;
    logic [10:0] frame_q;
    logic [3:0]  tick_q;
    logic [3:0]  bit_q;
    logic        active_q;
    logic        done_q;

    logic        parity_d;
    logic [10:0] frame_d;

    always_comb begin
        parity_d = 1'b1;
        case (parity_type)
            2'b01:   parity_d = ~(^data_in);
            2'b10:   parity_d = ^data_in;
            default: parity_d = 1'b1;
        endcase
        frame_d = {1'b1, parity_d, data_in, 1'b0};
    end

    // frame_q[0] is the line itself; shifting in ones leaves it idle-high
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            frame_q  <= '1;
            tick_q   <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tick_q   <= '0;
                    bit_q    <= '0;
                    active_q <= 1'b0;
                    if (send) begin
                        frame_q  <= frame_d;
                        active_q <= 1'b1;
                        state_q  <= SHIFT;
                    end else begin
                        frame_q <= '1;
                    end
                end
                SHIFT: begin
                    if (tick_q >= TICK_LAST) begin
                        tick_q <= '0;
                        if (bit_q >= BIT_LAST) begin
                            state_q  <= IDLE;
                            frame_q  <= '1;
                            bit_q    <= '0;
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            frame_q <= {1'b1, frame_q[10:1]};
                            bit_q   <= bit_q + 4'd1;
                        end
                    end else begin
                        tick_q <= tick_q + 4'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    frame_q  <= '1;
                    tick_q   <= '0;
                    bit_q    <= '0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_tx     = frame_q[0];
    assign active_flag = active_q;
    assign done_flag   = done_q;

endmodule

// File: tb/tb_uart_tx_piso.sv
// Directed testbench for uart_tx_piso: frame shape, parity, send
// masking, back-to-back frames and mid-frame reset.
module tb_uart_tx_piso;

    localparam int T         = 16;
    localparam int FRAME_CYC = 11 * T;

    logic       baud_clk;
    logic       reset_n;
    logic       send;
    logic [7:0] data_in;
    logic [1:0] parity_type;
    logic       data_tx;
    logic       active_flag;
    logic       done_flag;

    int errors = 0;
    int checks = 0;

    uart_tx_piso #(.TICKS_PER_BIT(T)) dut (
        .baud_clk   (baud_clk),
        .reset_n    (reset_n),
        .send       (send),
        .data_in    (data_in),
        .parity_type(parity_type),
        .data_tx    (data_tx),
        .active_flag(active_flag),
        .done_flag  (done_flag)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic start_frame(input logic [7:0] d, input logic [1:0] p);
        @(negedge baud_clk);
        send = 1'b1; data_in = d; parity_type = p;
        @(negedge baud_clk);
        send = 1'b0; data_in = 8'h00; parity_type = 2'b00;
    endtask

    // Observes one frame from the negedge after the accepting edge.
    task automatic watch_frame(
        input  logic [10:0] exp,
        input  int          inject_at,
        output int          bitbad,
        output int          actcnt,
        output int          donecnt,
        output logic [10:0] cap,
        output logic        end_tx,
        output logic        end_act,
        output logic        end_done
    );
        bitbad = 0; actcnt = 0; donecnt = 0; cap = 'x;
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (data_tx !== exp[i / T]) bitbad++;
            if (active_flag === 1'b1) actcnt++;
            if (done_flag !== 1'b0) donecnt++;
            if (i % T == T / 2) cap[i / T] = data_tx;
            if (inject_at >= 0 && i == inject_at) begin
                send = 1'b1; data_in = 8'hFF; parity_type = 2'b01;
            end
            if (inject_at >= 0 && i == inject_at + 1) send = 1'b0;
            @(negedge baud_clk);
        end
        end_tx = data_tx; end_act = active_flag; end_done = done_flag;
    endtask

    task automatic test_reset;
        int bad;
        reset_n = 1'b0; send = 1'b0; data_in = 8'h00; parity_type = 2'b00;
        repeat (3) @(negedge baud_clk);
        checks++;
        if (data_tx !== 1'b1) begin
            errors++; $display("FAIL rst_tx: got %b expected 1", data_tx);
        end
        checks++;
        if (active_flag !== 1'b0) begin
            errors++; $display("FAIL rst_active: got %b expected 0", active_flag);
        end
        checks++;
        if (done_flag !== 1'b0) begin
            errors++; $display("FAIL rst_done: got %b expected 0", done_flag);
        end
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge baud_clk);
            if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL idle_50: bad samples %0d expected 0", bad);
        end
    endtask

    task automatic test_frame_a5;
        int bb, ac, dc;
        logic [10:0] cap;
        logic et, ea, ed;
        logic [10:0] exp;
        exp = 11'b1_0_10100101_0;
        start_frame(8'hA5, 2'b10);
        watch_frame(exp, -1, bb, ac, dc, cap, et, ea, ed);
        checks++;
        if (bb != 0) begin
            errors++; $display("FAIL a5_bits: bad samples %0d expected 0", bb);
        end
        checks++;
        if (cap !== exp) begin
            errors++; $display("FAIL a5_capture: got %b expected %b", cap, exp);
        end
        checks++;
        if (ac != FRAME_CYC) begin
            errors++; $display("FAIL a5_active_len: got %0d expected %0d", ac, FRAME_CYC);
        end
        checks++;
        if (dc != 0) begin
            errors++; $display("FAIL a5_early_done: got %0d expected 0", dc);
        end
        checks++;
        if (ed !== 1'b1 || ea !== 1'b0 || et !== 1'b1) begin
            errors++;
            $display("FAIL a5_end: done=%b act=%b tx=%b expected 1 0 1", ed, ea, et);
        end
        @(negedge baud_clk);
        checks++;
        if (done_flag !== 1'b0 || data_tx !== 1'b1) begin
            errors++;
            $display("FAIL a5_done_pulse: done=%b tx=%b expected 0 1", done_flag, data_tx);
        end
    endtask

    task automatic test_parity;
        logic [1:0]  pt  [3];
        logic [10:0] exf [3];
        int bb, ac, dc;
        logic [10:0] cap;
        logic et, ea, ed;
        pt[0] = 2'b01; exf[0] = 11'b1_0_00000001_0;
        pt[1] = 2'b10; exf[1] = 11'b1_1_00000001_0;
        pt[2] = 2'b00; exf[2] = 11'b1_1_00000001_0;
        for (int k = 0; k < 3; k++) begin
            start_frame(8'h01, pt[k]);
            watch_frame(exf[k], -1, bb, ac, dc, cap, et, ea, ed);
            checks++;
            if (cap !== exf[k] || bb != 0) begin
                errors++;
                $display("FAIL parity_%0d: got %b (bad %0d) expected %b", k, cap, bb, exf[k]);
            end
            checks++;
            if (ed !== 1'b1) begin
                errors++; $display("FAIL parity_done_%0d: got %b expected 1", k, ed);
            end
            repeat (3) @(negedge baud_clk);
        end
    endtask

    task automatic test_ignore_send;
        int bb, ac, dc, act_after;
        logic [10:0] cap;
        logic et, ea, ed;
        logic [10:0] exp;
        exp = 11'b1_0_00111100_0;
        start_frame(8'h3C, 2'b10);
        watch_frame(exp, 40, bb, ac, dc, cap, et, ea, ed);
        checks++;
        if (cap !== exp || bb != 0) begin
            errors++;
            $display("FAIL ignore_bits: got %b (bad %0d) expected %b", cap, bb, exp);
        end
        checks++;
        if (ac != FRAME_CYC || ed !== 1'b1) begin
            errors++;
            $display("FAIL ignore_len: active %0d done %b expected %0d 1", ac, ed, FRAME_CYC);
        end
        act_after = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge baud_clk);
            if (active_flag !== 1'b0 || data_tx !== 1'b1) act_after++;
        end
        checks++;
        if (act_after != 0) begin
            errors++; $display("FAIL ignore_no_second: got %0d expected 0", act_after);
        end
    endtask

    task automatic test_back_to_back;
        int bb, ac, dc;
        logic [10:0] cap;
        logic et, ea, ed;
        logic [10:0] exp;
        exp = 11'b1_0_01010101_0;
        @(negedge baud_clk);
        send = 1'b1; data_in = 8'h55; parity_type = 2'b10;
        @(negedge baud_clk);
        watch_frame(exp, -1, bb, ac, dc, cap, et, ea, ed);
        checks++;
        if (bb != 0 || ac != FRAME_CYC) begin
            errors++; $display("FAIL b2b_frame1: bad %0d active %0d expected 0 %0d", bb, ac, FRAME_CYC);
        end
        checks++;
        if (et !== 1'b1 || ed !== 1'b1 || ea !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: tx=%b done=%b act=%b expected 1 1 0", et, ed, ea);
        end
        @(negedge baud_clk);
        checks++;
        if (data_tx !== 1'b0 || active_flag !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: tx=%b act=%b expected 0 1", data_tx, active_flag);
        end
        watch_frame(exp, -1, bb, ac, dc, cap, et, ea, ed);
        send = 1'b0;
        checks++;
        if (bb != 0 || ac != FRAME_CYC || ed !== 1'b1) begin
            errors++;
            $display("FAIL b2b_frame2: bad %0d active %0d done %b expected 0 %0d 1", bb, ac, ed, FRAME_CYC);
        end
        @(negedge baud_clk);
        checks++;
        if (active_flag !== 1'b0 || data_tx !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stop: act=%b tx=%b expected 0 1", active_flag, data_tx);
        end
    endtask

    task automatic test_reset_midframe;
        int bad, bb, ac, dc;
        logic [10:0] cap;
        logic et, ea, ed;
        logic [10:0] exp1;
        logic [10:0] exp2;
        exp1 = 11'b1_1_11000011_0;
        exp2 = 11'b1_0_10100101_0;
        start_frame(8'hC3, 2'b00);
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            if (data_tx !== exp1[i / T]) bad++;
            @(negedge baud_clk);
        end
        checks++;
        if (bad != 0 || data_tx !== 1'b0) begin
            errors++; $display("FAIL mid_prefix: bad %0d tx %b expected 0 0", bad, data_tx);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: tx=%b act=%b done=%b expected 1 0 0", data_tx, active_flag, done_flag);
        end
        bad = 0;
        repeat (3) begin
            @(negedge baud_clk);
            if (done_flag !== 1'b0 || active_flag !== 1'b0) bad++;
        end
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge baud_clk);
            if (done_flag !== 1'b0 || active_flag !== 1'b0 || data_tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mid_quiet: bad samples %0d expected 0", bad);
        end
        start_frame(8'hA5, 2'b10);
        watch_frame(exp2, -1, bb, ac, dc, cap, et, ea, ed);
        checks++;
        if (cap !== exp2 || bb != 0 || ac != FRAME_CYC || ed !== 1'b1) begin
            errors++;
            $display("FAIL mid_clean: got %b bad %0d act %0d done %b expected %b 0 %0d 1",
                     cap, bb, ac, ed, exp2, FRAME_CYC);
        end
    endtask

    initial begin
        test_reset;
        test_frame_a5;
        test_parity;
        test_ignore_send;
        test_back_to_back;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_piso.md
Name: uart_tx_piso

Overview:
- Parallel-In-Serial-Out transmitter for the UART link. It is the counterpart of the UART-Rx SIPO/DeFrame path.
- Accepts an 8-bit byte plus a parity mode on a single-cycle send strobe. It builds an 11-bit frame and shifts it out on data_tx.
- Frame order: start, data LSB first, parity, stop.
- Runs on the same oversampled baud_clk as the receiver. Each frame bit is held TICKS_PER_BIT clock edges so the Rx centre-sampling lands mid-bit.

Parameters:
- TICKS_PER_BIT, 16, baud_clk edges per serial bit; legal range 2..16; the tick counter is 4 bits wide.

Ports:
- baud_clk  input  1  oversampling clock, rising-edge active, from the baud generator
- reset_n  input  1  asynchronous active-low reset
- send  input  1  request strobe; sampled only in IDLE
- data_in  input  8  byte to transmit; sampled with send
- parity_type  input  2  01 odd, 10 even, 00/11 no parity (the parity slot carries 1); sampled with send
- data_tx  output  1  serial line, registered, idles high
- active_flag  output  1  high while a frame is on the line
- done_flag  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Single clock baud_clk; asynchronous active-low reset reset_n; all state updates on the rising edge of baud_clk.
- Reset values:
  - data_tx=1, active_flag=0, done_flag=0.
  - frame register = all ones, tick counter=0, bit counter=0, state=IDLE.
- Reset asserted mid-frame aborts immediately: line returns high, the frame is discarded, and no done_flag is produced.
- State machine: IDLE, SHIFT.
- IDLE:
  - data_tx=1, counters held at 0.
  - If send=1 at an edge:
    - Latch frame = {stop=1, parity, data_in[7:0], start=0}; transmit order is bit 0 first.
    - data_tx<=0 on that same edge, active_flag<=1, state<=SHIFT.
  - If send=0, remain in IDLE.
- Parity: even = XOR of data_in; odd = inverted XOR; none = 1.
- SHIFT:
  - Tick counter increments each edge.
  - At tick==TICKS_PER_BIT-1 with bit counter<10: tick<=0, bit counter+1, data_tx<=next frame bit.
  - At tick==TICKS_PER_BIT-1 with bit counter==10 (stop bit finished): state<=IDLE, active_flag<=0, done_flag<=1 for exactly one cycle, data_tx stays 1.
- Latency:
  - Line falls on the accepting edge.
  - Each bit lasts exactly TICKS_PER_BIT cycles.
  - active_flag stays high for 11*TICKS_PER_BIT cycles (176 at default).
- send, data_in and parity_type are ignored while active_flag=1. Changing data_in mid-frame does not alter the frame.
- send held high continuously:
  - A new frame is accepted on the first IDLE edge, i.e. the cycle done_flag is high.
  - The minimum inter-frame idle is therefore 1 cycle of data_tx=1.
- send pulses shorter than one cycle are not supported; send must be synchronous to baud_clk.
- done_flag and active_flag are never high in the same cycle.
- Wrap-around: counters never exceed TICKS_PER_BIT-1 and 10. Illegal state encodings return to IDLE with data_tx=1.

Test Plan:
- Reset release, send=0 for 50 cycles -> data_tx=1, active_flag=0, done_flag=0 throughout.
- send 0xA5, even parity -> line sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 16 cycles; active_flag high 176 cycles; done_flag pulse once. Loopback into the Rx SIPO gives data_parll=11'b0_10100101_0_1 with recieved_flag.
- send 0x01 with odd, then even, then none -> parity slot = 0, 1, 1 respectively; all other bits match 0,1,0,0,0,0,0,0,0,p,1.
- send re-pulsed with data 0xFF at cycle 40 of a 0x3C frame -> transmitted bits still those of 0x3C; no second frame starts.
- send held high, data 0x55 -> back-to-back frames with exactly 1 idle-high cycle between stop bit end and next start bit.
- reset_n asserted at cycle 70 of a frame -> data_tx=1 and active_flag=0 immediately, no done_flag. After release, a new send transmits a clean full frame.
